// File: rtl/segway_pkg.sv
// Shared types and default thresholds for the segway balance datapath.
// Rider detection uses summed load-cell counts in A2D units.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;

endpackage

// File: rtl/steer_tmr.sv
// Saturating settle timer for steer_en.
// Counts every cycle, clear wins, holds at full.
module steer_tmr
    import segway_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic full
);

    logic [25:0] cnt;

    // Only the low 15 bits matter when simulating fast.
    assign full = FAST_SIM ? (&cnt[14:0]) : (&cnt);

    // Clear has priority; stop counting once full so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!full) begin
            cnt <= cnt + 26'd1;
        end
    end

endmodule

// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller.
// Load-cell thresholds feed a three-state enable FSM.
module steer_en
    import segway_pkg::*;
#(
    parameter bit          FAST_SIM      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] WT_HI =
        {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] WT_LO =
        {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    steer_state_t state;
    steer_state_t nxt;

    logic [12:0] sum;
    logic [12:0] diff;
    logic [11:0] abs_diff;
    logic [12:0] abs_ext;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        clr_tmr;
    logic        tmr_full;

    assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff = {1'b0, lft_ld} - {1'b0, rght_ld};

    // Magnitude of a 13-bit difference of 12-bit values fits in 12 bits.
    always_comb begin
        abs_diff = diff[12] ? 12'(-diff) : diff[11:0];
    end

    assign abs_ext       = {1'b0, abs_diff};
    assign sum_gt_min    = sum > WT_HI;
    assign sum_lt_min    = sum < WT_LO;
    assign diff_gt_1_4   = abs_ext > (sum >> 2);
    assign diff_gt_15_16 = abs_ext > (sum - (sum >> 4));

    steer_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_tmr),
        .full  (tmr_full)
    );

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state and timer clear, first matching condition wins.
    always_comb begin
        nxt     = state;
        clr_tmr = 1'b0;
        unique case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt     = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    nxt = STEER;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt     = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    assign en_steer  = (state == STEER);
    assign rider_off = (state == IDLE);

endmodule

// File: tb/tb_steer_en.sv
// Randomized and scenario bench for steer_en.
// A cycle-level rule model predicts both outputs.
module tb_steer_en;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int n_vec;
    int n_err;

    // Model: 0 = no rider, 1 = settling, 2 = steering.
    int m_st;
    int m_cnt;

    localparam int FULL_CNT = 32767;

    steer_en #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Behavioural model straight from the rider rules, integer arithmetic.
    always @(posedge clk or negedge rst_n) begin : model
        int s;
        int ad;
        int nst;
        bit clr;
        if (!rst_n) begin
            m_st  <= 0;
            m_cnt <= 0;
        end else begin
            s   = int'(lft_ld) + int'(rght_ld);
            ad  = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld)
                                     : int'(rght_ld) - int'(lft_ld);
            nst = m_st;
            clr = 1'b0;
            if (m_st == 0) begin
                if (s > 576) begin
                    nst = 1;
                    clr = 1'b1;
                end
            end else if (m_st == 1) begin
                if (s < 448) nst = 0;
                else if (ad > s / 4) clr = 1'b1;
                else if (m_cnt >= FULL_CNT) nst = 2;
            end else begin
                if (s < 448) nst = 0;
                else if (ad > s - s / 16) begin
                    nst = 1;
                    clr = 1'b1;
                end
            end
            m_st  <= nst;
            m_cnt <= clr ? 0 : ((m_cnt >= FULL_CNT) ? FULL_CNT : m_cnt + 1);
        end
    end

    // Every cycle, compare outputs against the model mid-period.
    always @(negedge clk) begin
        chk("en_steer", int'(en_steer), int'(m_st == 2));
        chk("rider_off", int'(rider_off), int'(m_st == 0));
    end

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        @(negedge clk);
        lft_ld  = l;
        rght_ld = r;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en_steer", int'(en_steer), 0);
        chk("async_rider_off", int'(rider_off), 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called right after inputs change; returns negedges until en_steer.
    task automatic wait_steer(output int k);
        k = 0;
        while (!en_steer && k < 40000) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        int mode;
        logic [11:0] b;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        lft_ld  = '0;
        rght_ld = '0;
        repeat (3) @(negedge clk);
        chk("reset_en_steer", int'(en_steer), 0);
        chk("reset_rider_off", int'(rider_off), 1);
        #1 rst_n = 1'b1;

        // Random loads: thresholds, balance bands and extremes.
        for (int i = 0; i < 200; i++) begin
            mode = int'($urandom_range(0, 5));
            b    = 12'($urandom_range(12'h0C0, 12'h140));
            case (mode)
                0: drive(12'($urandom), 12'($urandom));
                1: drive(b, b);
                2: drive(12'hFFF, 12'hFFF);
                3: drive(12'hFFF, 12'h000);
                4: drive(12'($urandom_range(0, 12'h300)),
                         12'($urandom_range(0, 12'h300)));
                default: drive(12'h000, 12'h000);
            endcase
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        pulse_reset();
        drive(12'h000, 12'h000);
        repeat (5) @(negedge clk);
        chk("idle_zero_load", int'(rider_off), 1);

        // Unbalanced mount: present but never settles.
        drive(12'h200, 12'h0A0);
        @(negedge clk);
        chk("unbal_rider_on", int'(rider_off), 0);
        repeat (3000) @(negedge clk);
        chk("unbal_no_steer", int'(en_steer), 0);
        chk("unbal_rider_on_hold", int'(rider_off), 0);

        // Rebalance: full settle time from the last clear.
        drive(12'h200, 12'h200);
        wait_steer(k);
        chk("rebal_latency_ok", int'(k - 1 >= 32766 && k - 1 <= 32770), 1);

        // Sum inside the hysteresis band keeps steering.
        drive(12'h0E8, 12'h0E8);
        repeat (1000) @(negedge clk);
        chk("hyst_hold_steer", int'(en_steer), 1);

        // Step-off while steering drops to settling.
        drive(12'h2A0, 12'h000);
        @(negedge clk);
        chk("stepoff_en_steer", int'(en_steer), 0);
        chk("stepoff_rider_on", int'(rider_off), 0);

        // Reset partway through a balanced settle restarts the wait.
        drive(12'h150, 12'h150);
        repeat (20000) @(negedge clk);
        chk("mid_wait_no_steer", int'(en_steer), 0);
        pulse_reset();
        wait_steer(k);
        chk("restart_latency_ok", int'(k - 1 >= 32766 && k - 1 <= 32770), 1);

        // Sum below the band from steering: rider off next clock.
        drive(12'h0D8, 12'h0D8);
        @(negedge clk);
        chk("lowsum_en_steer", int'(en_steer), 0);
        chk("lowsum_rider_off", int'(rider_off), 1);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
